seq_stream_ctrl: RTL and testbench
==================================

// Module: seq_stream_ctrl
// PURPOSE
//  Controller that sequences the bit-serial sequence-detector FSM (inputs clk, x; output Z).
//  Accepts a parallel stimulus frame over a valid/ready handshake.
//  Shifts the frame MSB-first onto the detector's x input, one bit per clock.
//  Counts the detector's Z pulses per frame and reports the count once the frame completes.
// PARAMETERS
//  FRAME_W  24  bits per frame shifted to the detector (>=2)
//  CNT_W     5  width of the match counter; counter saturates at 2^CNT_W-1
//  GAP       1  idle cycles (det_x=0, frm_ready=0) after each report; 0 = none
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  frm_data     in   FRAME_W  stimulus frame; bit FRAME_W-1 is sent first
//  frm_valid    in   1        frame offered
//  frm_ready    out  1        controller can accept a frame
//  frm_clr      in   1        clear the detector before this frame; sampled with frm_data
//  det_x        out  1        serial bit to the detector x input (registered)
//  det_clr      out  1        one-cycle synchronous clear to the detector
//  det_z        in   1        detector Z output (Mealy; valid in the same cycle as det_x)
//  match_cnt    out  CNT_W    Z pulses counted in the last frame
//  match_valid  out  1        one-cycle strobe; match_cnt and overflow are valid
//  overflow     out  1        counter saturated during the last frame
//  busy         out  1        high in any state except IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous):
//      state=IDLE; all outputs 0 except frm_ready, which is 1 from the first edge after release.
//      Match counter, overflow and shift register are cleared.
//  - FSM states: IDLE, CLR, SHIFT, REPORT, GAP.
//  - IDLE: frm_ready=1, det_x=0.
//      On a clock edge with frm_valid & frm_ready: capture frm_data and frm_clr,
//      clear the count and overflow, then go to CLR if frm_clr=1, else SHIFT.
//  - CLR: exactly 1 cycle with det_clr=1 and det_x=0, then SHIFT.
//  - SHIFT: lasts exactly FRAME_W cycles.
//      Cycle k (k=0..FRAME_W-1) drives det_x = frame bit FRAME_W-1-k.
//      det_z is sampled at the end of each SHIFT cycle; when det_z=1, count += 1.
//      If count is already 2^CNT_W-1, it holds and overflow is set (sticky for the frame).
//      det_z is ignored in every other state.
//      After the last bit, go to REPORT.
//  - REPORT: 1 cycle.
//      match_valid=1; match_cnt = final count; overflow = final flag.
//      Next state is GAP if GAP>0, else IDLE.
//      match_cnt and overflow hold their values until the next frame is accepted.
//  - GAP: GAP cycles with det_x=0 and frm_ready=0, then IDLE.
//  - Latency:
//      Accept edge -> first bit: 1 cycle, or 2 cycles with frm_clr.
//      match_valid rises FRAME_W cycles after the first bit.
//      Minimum frame-to-frame period is FRAME_W+2+GAP cycles (frm_clr adds 1).
//  - frm_ready=0 in every state except IDLE.
//      A frm_valid outside IDLE is not accepted; the producer holds frm_data and frm_valid.
//  - det_x is 0 in every state except SHIFT; det_clr is 0 in every state except CLR.
//  - Reset during SHIFT/CLR aborts the frame: no match_valid, and det_x returns to 0 immediately.
//  - A frame of all zeros with det_z never asserted reports match_cnt=0, overflow=0.
// STRUCTURE
//  - Package seqctl_pkg holds:
//      state enum {IDLE,CLR,SHIFT,REPORT,GAP};
//      localparam widths derived via $clog2(FRAME_W) and $clog2(GAP+1).
//  - Sub-module seq_frame_shifter holds the FRAME_W shift register and the down-counting bit index.
//      Interface: load, shift_en, out bit, last flag.
//  - The top level holds the FSM, the saturating match counter, the GAP counter and the output registers.
// TESTING
//  Bench stub drives det_z = det_x, so count = popcount of the frame.
//  1. Reset, then frame 24'hA50F3C, frm_clr=0 ->
//       det_x shows 1010_0101_0000_1111_0011_1100 over 24 cycles; match_cnt=12, overflow=0.
//  2. Frame 24'h800001, frm_clr=1 ->
//       det_clr high exactly 1 cycle before the first bit; match_cnt=2; busy for 27 cycles with GAP=1.
//  3. CNT_W=3, frame 24'hFFFFFF -> match_cnt=7, overflow=1; next frame 24'h000003 -> match_cnt=2, overflow=0.
//  4. frm_valid held high back-to-back with 24'h000001 then 24'h000000 ->
//       second accept exactly FRAME_W+2+GAP cycles after the first; reports 1 then 0.
//  5. Assert rst_n=0 at bit 10 of frame 24'hFFFFFF -> no match_valid; det_x=0 at once;
//       after release, frm_ready=1 and the next frame counts from 0.
//  6. Stub forces det_z=1 during IDLE and GAP -> no count change; frame 24'h0 reports match_cnt=0.

Source files
------------

// File: rtl/seqctl_pkg.sv
// Shared types and width helpers for the sequence-detector stream controller.
// Imported by the frame interface, the frame shifter and the controller top.
package seqctl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_REPORT,
        S_GAP
    } state_t;

    localparam int FRAME_W_DEF = 24;
    localparam int CNT_W_DEF   = 5;
    localparam int GAP_DEF     = 1;

    function automatic int idx_w(input int frame_w);
        return ($clog2(frame_w) < 1) ? 1 : $clog2(frame_w);
    endfunction

    function automatic int gap_w(input int gap);
        return ($clog2(gap + 1) < 1) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/seq_stream_ctrl_if.sv
// Frame handshake between a stimulus producer and the stream controller.
// frm_clr travels with frm_data and is sampled on the same accept edge.
interface seq_stream_ctrl_if
    import seqctl_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF
) ();
    logic [FRAME_W-1:0] frm_data;
    logic               frm_valid;
    logic               frm_ready;
    logic               frm_clr;

    modport master (
        output frm_data,
        output frm_valid,
        output frm_clr,
        input  frm_ready
    );

    modport slave (
        input  frm_data,
        input  frm_valid,
        input  frm_clr,
        output frm_ready
    );
endinterface

// File: rtl/seq_frame_shifter.sv
// MSB-first frame shift register with a down-counting bit index.
// o_bit is the MSB this register will hold after the coming edge.
module seq_frame_shifter
    import seqctl_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_data,
    input  logic               i_shift_en,
    output logic               o_bit,
    output logic               o_last
);
    localparam int            IW      = idx_w(FRAME_W);
    localparam logic [IW-1:0] IDX_TOP = IW'(FRAME_W - 1);

    logic [FRAME_W-1:0] r_sreg;
    logic [IW-1:0]      r_idx;

    // Load a new frame or advance one bit; index counts bits still to go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
            r_idx  <= IDX_TOP;
        end else if (i_shift_en) begin
            r_sreg <= {r_sreg[FRAME_W-2:0], 1'b0};
            r_idx  <= r_idx - 1'b1;
        end
    end

    // Look-ahead bit so the caller can register it as det_x directly.
    always_comb begin
        o_bit = r_sreg[FRAME_W-1];
        unique case (1'b1)
            i_load:     o_bit = i_data[FRAME_W-1];
            i_shift_en: o_bit = r_sreg[FRAME_W-2];
            default:    o_bit = r_sreg[FRAME_W-1];
        endcase
    end

    assign o_last = (r_idx == '0);

endmodule

// File: rtl/seq_stream_ctrl.sv
// Sequences a bit-serial detector: shifts a frame onto det_x MSB-first,
// counts det_z pulses with saturation and reports the count per frame.
module seq_stream_ctrl
    import seqctl_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int GAP     = GAP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_stream_ctrl_if.slave   frm,
    output logic               det_x,
    output logic               det_clr,
    input  logic               det_z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               match_valid,
    output logic               overflow,
    output logic               busy
);
    localparam int               GW      = gap_w(GAP);
    localparam logic [GW-1:0]    GAP_LD  = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [GW-1:0]    r_gap;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_det_x;
    logic             r_det_clr;
    logic             r_mv;
    logic             r_ready;
    logic             r_busy;

    logic w_accept;
    logic w_shift;
    logic w_bit;
    logic w_last;

    assign w_accept = (r_state == S_IDLE) & r_ready & frm.frm_valid;
    assign w_shift  = (r_state == S_SHIFT) & ~w_last;

    seq_frame_shifter #(
        .FRAME_W (FRAME_W)
    ) u_shf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_data     (frm.frm_data),
        .i_shift_en (w_shift),
        .o_bit      (w_bit),
        .o_last     (w_last)
    );

    // Frame FSM with registered handshake, detector and report outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gap     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_det_x   <= 1'b0;
            r_det_clr <= 1'b0;
            r_mv      <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_det_x   <= 1'b0;
            r_det_clr <= 1'b0;
            r_mv      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (frm.frm_clr) begin
                            r_state   <= S_CLR;
                            r_det_clr <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_det_x <= w_bit;
                        end
                    end
                end
                S_CLR: begin
                    r_state <= S_SHIFT;
                    r_det_x <= w_bit;
                end
                S_SHIFT: begin
                    if (det_z) begin
                        if (r_cnt == CNT_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    if (w_last) begin
                        r_state <= S_REPORT;
                        r_mv    <= 1'b1;
                    end else begin
                        r_det_x <= w_bit;
                    end
                end
                S_REPORT: begin
                    if (GAP > 0) begin
                        r_state <= S_GAP;
                        r_gap   <= GAP_LD;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign frm.frm_ready = r_ready;
    assign det_x         = r_det_x;
    assign det_clr       = r_det_clr;
    assign match_cnt     = r_cnt;
    assign match_valid   = r_mv;
    assign overflow      = r_ovf;
    assign busy          = r_busy;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Directed bench: two controllers (CNT_W=5 and CNT_W=3) run in lockstep,
// each with a detector stub that echoes det_x back as det_z.
module tb_seq_stream_ctrl;
    localparam int W = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_stream_ctrl_if #(.FRAME_W(W)) ifa ();
    seq_stream_ctrl_if #(.FRAME_W(W)) ifb ();

    logic       dxa, dca, dza, mva, ova, bza;
    logic [4:0] cnta;
    logic       dxb, dcb, dzb, mvb, ovb, bzb;
    logic [2:0] cntb;
    logic       zf      = 1'b0;
    logic       gap_win = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    assign ifb.frm_data  = ifa.frm_data;
    assign ifb.frm_valid = ifa.frm_valid;
    assign ifb.frm_clr   = ifa.frm_clr;

    // GAP=1: the cycle after the match_valid strobe is the GAP cycle.
    always @(posedge clk) gap_win <= mva;

    assign dza = dxa | (zf & (ifa.frm_ready | mva | gap_win));
    assign dzb = dxb | (zf & (ifb.frm_ready | mvb | gap_win));

    seq_stream_ctrl #(.FRAME_W(W), .CNT_W(5), .GAP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .frm(ifa),
        .det_x(dxa), .det_clr(dca), .det_z(dza),
        .match_cnt(cnta), .match_valid(mva),
        .overflow(ova), .busy(bza)
    );

    seq_stream_ctrl #(.FRAME_W(W), .CNT_W(3), .GAP(1)) u_b (
        .clk(clk), .rst_n(rst_n), .frm(ifb),
        .det_x(dxb), .det_clr(dcb), .det_z(dzb),
        .match_cnt(cntb), .match_valid(mvb),
        .overflow(ovb), .busy(bzb)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // Offer one frame, then observe 40 cycles from the accept edge.
    task automatic run_frame(input logic [W-1:0] d, input logic c,
                             input int ea, input int oa,
                             input int eb, input int ob,
                             input string tag);
        logic [W-1:0] bits;
        int clrs, clr_at, mvs, mv_at, cnt_mv, bsy, stray, lock, n;
        bits = '0; clrs = 0; clr_at = -1; mvs = 0; mv_at = -1;
        cnt_mv = -1; bsy = 0; stray = 0; lock = 0; n = 0;
        ifa.frm_data  = d;
        ifa.frm_clr   = c;
        ifa.frm_valid = 1'b1;
        while (!ifa.frm_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_rdy", tag), int'(n < 50), 1);
        @(posedge clk);
        @(negedge clk);
        ifa.frm_valid = 1'b0;
        ifa.frm_data  = '0;
        ifa.frm_clr   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dca) begin
                clrs++;
                clr_at = i;
            end
            if (i >= int'(c) && i < int'(c) + W)
                bits[W-1-(i-int'(c))] = dxa;
            else if (dxa)
                stray++;
            if (mva) begin
                mvs++;
                mv_at  = i;
                cnt_mv = cnta;
            end
            bsy += int'(bza);
            if (dxb !== dxa || dcb !== dca || bzb !== bza || mvb !== mva)
                lock++;
            @(negedge clk);
        end
        chk($sformatf("%s_bits", tag), int'(bits), int'(d));
        chk($sformatf("%s_stray_x", tag), stray, 0);
        chk($sformatf("%s_clr_n", tag), clrs, int'(c));
        chk($sformatf("%s_clr_at", tag), clr_at, c ? 0 : -1);
        chk($sformatf("%s_mv_n", tag), mvs, 1);
        chk($sformatf("%s_mv_at", tag), mv_at, int'(c) + W);
        chk($sformatf("%s_busy", tag), bsy, int'(c) + W + 2);
        chk($sformatf("%s_cnt_mv", tag), cnt_mv, ea);
        chk($sformatf("%s_cnt_a", tag), int'(cnta), ea);
        chk($sformatf("%s_ovf_a", tag), int'(ova), oa);
        chk($sformatf("%s_cnt_b", tag), int'(cntb), eb);
        chk($sformatf("%s_ovf_b", tag), int'(ovb), ob);
        chk($sformatf("%s_lock", tag), lock, 0);
    endtask

    initial begin
        int acc2, nmv, mv1, mv2, n, mvs;
        ifa.frm_data  = '0;
        ifa.frm_valid = 1'b0;
        ifa.frm_clr   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", int'(ifa.frm_ready), 0);
        chk("rst_x", int'(dxa), 0);
        chk("rst_clr", int'(dca), 0);
        chk("rst_mv", int'(mva), 0);
        chk("rst_cnt", int'(cnta), 0);
        chk("rst_ovf", int'(ova), 0);
        chk("rst_busy", int'(bza), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", int'(ifa.frm_ready), 1);

        run_frame(24'hA50F3C, 1'b0, 12, 0, 7, 1, "t1");
        run_frame(24'h800001, 1'b1, 2, 0, 2, 0, "t2");
        run_frame(24'hFFFFFF, 1'b0, 24, 0, 7, 1, "t3a");
        run_frame(24'h000003, 1'b0, 2, 0, 2, 0, "t3b");

        // Back-to-back frames with frm_valid held high.
        ifa.frm_data  = 24'h000001;
        ifa.frm_clr   = 1'b0;
        ifa.frm_valid = 1'b1;
        n = 0;
        while (!ifa.frm_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_rdy", int'(n < 50), 1);
        @(posedge clk);
        @(negedge clk);
        ifa.frm_data = 24'h000000;
        acc2 = -1; nmv = 0; mv1 = -1; mv2 = -1;
        for (int i = 0; i < 70; i++) begin
            if (ifa.frm_ready && acc2 < 0)
                acc2 = i + 1;
            if (mva) begin
                if (nmv == 0) mv1 = cnta;
                else          mv2 = cnta;
                nmv++;
            end
            @(negedge clk);
            if (acc2 >= 0)
                ifa.frm_valid = 1'b0;
        end
        chk("t4_period", acc2, W + 3);
        chk("t4_mv_n", nmv, 2);
        chk("t4_cnt1", mv1, 1);
        chk("t4_cnt2", mv2, 0);

        // Reset while bit 10 of an all-ones frame is on det_x.
        ifa.frm_data  = 24'hFFFFFF;
        ifa.frm_valid = 1'b1;
        n = 0;
        while (!ifa.frm_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_rdy", int'(n < 50), 1);
        @(posedge clk);
        @(negedge clk);
        ifa.frm_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_pre_x", int'(dxa), 1);
        chk("t5_pre_busy", int'(bza), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_x", int'(dxa), 0);
        chk("t5_busy", int'(bza), 0);
        chk("t5_cnt", int'(cnta), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mvs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            mvs += int'(mva);
        end
        chk("t5_no_mv", mvs, 0);
        chk("t5_ready", int'(ifa.frm_ready), 1);
        run_frame(24'h0000F0, 1'b0, 4, 0, 4, 0, "t5n");

        // det_z forced high outside SHIFT must not be counted.
        zf = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(24'h000000, 1'b0, 0, 0, 0, 0, "t6a");
        run_frame(24'h000007, 1'b1, 3, 0, 3, 0, "t6b");
        zf = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
